// File: rtl/capi_reset_seq.sv
// Reset sequencer: drives a fixed-length reset pulse to downstream domains, waits for all
// domains ready, then pulses done. Optional WAIT timeout with sticky error: CAPI_RESET_SEQ_TMO_EN.
module capi_reset_seq #(
   parameter int PULSE_CYC = 15,
   parameter int NUM_DOM   = 4,
   parameter int TMO_W     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_req,
   output logic               o_req_ack,
   output logic               o_reset,
   input  logic [NUM_DOM-1:0] i_dom_rdy,
   output logic               o_done,
   output logic               o_busy,
   output logic               o_err,
   input  logic               i_err_clr
);

   // state  | meaning
   // IDLE   | sequence finished, waiting for a request
   // ASSERT | o_reset high, pulse counter running
   // WAIT   | o_reset low, waiting for every domain to report ready
   // DONE   | single-cycle completion, o_done high
   typedef enum logic [1:0] {IDLE, ASSERT, WAIT, DONE} state_t;

   localparam int CNT_W = $clog2(PULSE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYC - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             all_rdy;
   logic             tmo_expired;
   logic             tmo_hit;

   assign all_rdy = &i_dom_rdy;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmo_hit   = 1'b0;
      if (i_req) begin
         state_nxt = ASSERT;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            ASSERT: begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == CNT_LAST) state_nxt = WAIT;
            end
            WAIT: begin
               if (all_rdy) begin
                  state_nxt = DONE;
               end else if (tmo_expired) begin
                  state_nxt = DONE;
                  tmo_hit   = 1'b1;
               end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ASSERT;
         cnt       <= '0;
         o_reset   <= 1'b1;
         o_busy    <= 1'b1;
         o_done    <= 1'b0;
         o_req_ack <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         o_reset   <= (state_nxt == ASSERT);
         o_busy    <= (state_nxt != IDLE);
         o_done    <= (state_nxt == DONE);
         o_req_ack <= i_req;
      end
   end

`ifdef CAPI_RESET_SEQ_TMO_EN
   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_expired = &tmo_cnt;

   // Held at zero outside WAIT, so it is already clear on WAIT entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
      end else if (state != WAIT) begin
         tmo_cnt <= '0;
      end else if (!all_rdy) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_err <= 1'b0;
      end else if (tmo_hit) begin
         o_err <= 1'b1;
      end else if (i_err_clr) begin
         o_err <= 1'b0;
      end
   end
`else
   logic [TMO_W-1:0] unused_tmo;

   assign tmo_expired = 1'b0;
   assign o_err       = 1'b0;
   assign unused_tmo  = {TMO_W{i_err_clr & tmo_hit}};
`endif

endmodule

// File: doc/capi_reset_seq.md
# capi_reset_seq

Reset sequencer on the initiating side of the AFU reset handshake. It accepts reset requests from job control and drives a fixed-length reset pulse to the downstream logic domains. It then waits until every domain reports ready and signals completion to the requester. It also runs the same sequence automatically after power-on reset.

## Interface
- PULSE_CYC, 15, cycles `o_reset` is held high per sequence (≥1)
- NUM_DOM, 4, number of downstream domains reporting ready (≥1)
- TMO_W, 16, width of WAIT timeout counter; timeout = 2^TMO_W cycles (used only with CAPI_RESET_SEQ_TMO_EN)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  reset; asynchronous assert, active-low
- i_req  in  1  reset request, one-cycle pulse, synchronous to clk
- o_req_ack  out  1  one-cycle pulse: request accepted
- o_reset  out  1  active-high reset to downstream domains, registered
- i_dom_rdy  in  NUM_DOM  per-domain ready level, synchronous to clk (callers synchronize)
- o_done  out  1  one-cycle pulse: sequence complete
- o_busy  out  1  high whenever state ≠ IDLE, registered
- o_err  out  1  sticky timeout flag
- i_err_clr  in  1  clears o_err

## Operation
- States:
  - IDLE
  - ASSERT: `o_reset`=1; pulse counter `cnt`, width clog2(PULSE_CYC+1)
  - WAIT: `o_reset`=0
  - DONE: `o_done`=1, lasts one cycle
- Reset values:
  - state=ASSERT, cnt=0
  - o_reset=1, o_busy=1
  - o_req_ack=0, o_done=0, o_err=0
- Power-on: after reset_n deasserts, a full ASSERT→WAIT→DONE sequence runs.
  - o_done pulses at its end.
  - o_req_ack does not pulse.
- i_req=1 in any state:
  - next state ASSERT, cnt=0
  - o_req_ack=1 for the next cycle
- ASSERT: cnt increments each cycle. On the cycle with cnt==PULSE_CYC-1 and no i_req, next state is WAIT.
- WAIT: if &i_dom_rdy, next state is DONE.
- DONE: next state is IDLE unless i_req.
- i_req in the DONE cycle:
  - o_done still pulses that cycle.
  - The next state is ASSERT.
- i_req during ASSERT restarts the pulse. The result is one continuous o_reset, extended to PULSE_CYC cycles after the last accepted request. Each request is acked; only one o_done is produced.
- i_req during WAIT returns to ASSERT. No o_done is produced for the abandoned sequence.
- i_dom_rdy is ignored outside WAIT.

## Timing
- i_req sampled high at edge T:
  - o_reset and o_req_ack are high from cycle T+1.
  - o_reset stays high for cycles T+1..T+PULSE_CYC.
  - The state is WAIT at T+PULSE_CYC+1.
- Minimum request→o_done latency is PULSE_CYC+2 cycles, reached when all i_dom_rdy are high during the first WAIT cycle.
- o_done is asserted the cycle after the WAIT cycle in which &i_dom_rdy is sampled.
- reset_n low forces o_reset=1 immediately (asynchronously), from any state. o_done and o_req_ack are cleared immediately.
- o_busy falls in the cycle after DONE.

## Configuration
- CAPI_RESET_SEQ_TMO_EN defined:
  - A TMO_W-bit counter clears on WAIT entry and increments each WAIT cycle without &i_dom_rdy.
  - On the cycle with count==2^TMO_W-1 and still not ready, next state is DONE.
  - o_err sets in the DONE cycle; o_done pulses normally.
  - o_err stays set until i_err_clr. If i_err_clr and a new timeout occur in the same cycle, set wins.
- Not defined:
  - WAIT persists indefinitely until &i_dom_rdy or i_req.
  - o_err is tied 0; i_err_clr is ignored.

## Test plan
- Power-on: reset_n low 5 cycles, i_dom_rdy=4'hF → o_reset high during reset and for the first 15 clk edges after release; o_done high exactly once, 17 cycles after release; no o_req_ack.
- Single request from IDLE, i_dom_rdy=4'h0 until 40 cycles after the request, then 4'hF → o_req_ack at T+1, o_reset T+1..T+15, o_done one cycle after rdy is sampled at 4'hF, o_busy low on the following cycle.
- Re-trigger: second i_req at ASSERT cnt=10 → o_reset continuous for 26 cycles total, two o_req_ack pulses, exactly one o_done.
- i_req while in WAIT with i_dom_rdy=4'h7 → ASSERT re-entered, o_reset high 15 more cycles, no o_done until the second sequence completes.
- TMO_W=4 with macro defined, i_dom_rdy stuck at 4'hE → after 16 WAIT cycles DONE: o_done and o_err rise together; o_err holds until i_err_clr pulse; without macro → no o_done, o_err=0.
- reset_n asserted mid-WAIT → o_reset high without waiting for a clk edge, o_busy=1; full sequence reruns after release.
